mul_product_accumulator: RTL and testbench



---
 rtl/mul_product_accumulator.sv | 144 ++++++++++++++
 tb/tb_mul_product_accumulator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_product_accumulator.sv
// Sums groups of multiplier products into a wide accumulator and hands each
// group total downstream; supports signed/unsigned, saturate/wrap and a sticky overflow flag.
module mul_product_accumulator #(
  parameter int PROD_SIZE = 64,
  parameter int ACC_SIZE  = 72,
  parameter int LEN_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PROD_SIZE-1:0] in_prod,
  input  logic                 in_prod_signed,
  input  logic [LEN_W-1:0]     in_len,
  input  logic                 in_sat_en,
  input  logic                 in_valid,
  output logic                 out_ready,
  output logic [ACC_SIZE-1:0]  out_acc,
  output logic                 out_ovf,
  output logic                 out_valid,
  input  logic                 in_ready
);

  localparam int EXT_W = ACC_SIZE - PROD_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SEND  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ACC_SIZE-1:0] acc_q, acc_d;
  logic [LEN_W:0]      count_q, count_d;
  logic [LEN_W:0]      len_q, len_d;
  logic                ovf_q, ovf_d;
  logic                signed_q, signed_d;
  logic                sat_q, sat_d;

  logic                get_hsked;
  logic                send_hsked;
  logic                ext_sign;
  logic [ACC_SIZE-1:0] addend;
  logic [ACC_SIZE:0]   sum_full;
  logic                ovf_unsigned;
  logic                ovf_signed;
  logic                add_ovf;
  logic [ACC_SIZE-1:0] sat_val;
  logic [LEN_W:0]      len_eff;
  logic [LEN_W:0]      count_inc;

  assign get_hsked  = in_valid & out_ready;
  assign send_hsked = out_valid & in_ready;

  // The first product of a group must be extended with the incoming signedness,
  // later ones with the signedness latched at group start.
  assign ext_sign = (state_q == IDLE) ? in_prod_signed : signed_q;
  assign addend   = {{EXT_W{ext_sign & in_prod[PROD_SIZE-1]}}, in_prod};

  assign sum_full     = {1'b0, acc_q} + {1'b0, addend};
  assign ovf_unsigned = sum_full[ACC_SIZE];
  assign ovf_signed   = (acc_q[ACC_SIZE-1] == addend[ACC_SIZE-1]) &&
                        (sum_full[ACC_SIZE-1] != acc_q[ACC_SIZE-1]);
  assign add_ovf      = signed_q ? ovf_signed : ovf_unsigned;

  always_comb begin
    sat_val = '1;
    if (signed_q) begin
      sat_val = addend[ACC_SIZE-1] ? {1'b1, {(ACC_SIZE-1){1'b0}}}
                                   : {1'b0, {(ACC_SIZE-1){1'b1}}};
    end
  end

  assign len_eff   = (in_len == '0) ? {{LEN_W{1'b0}}, 1'b1} : {1'b0, in_len};
  assign count_inc = count_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      signed_q <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      signed_q <= signed_d;
      sat_q    <= sat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    signed_d = signed_q;
    sat_d    = sat_q;
    case (state_q)
      IDLE: begin
        if (get_hsked) begin
          signed_d = in_prod_signed;
          sat_d    = in_sat_en;
          len_d    = len_eff;
          acc_d    = addend;
          count_d  = {{LEN_W{1'b0}}, 1'b1};
          ovf_d    = 1'b0;
          state_d  = (len_eff == {{LEN_W{1'b0}}, 1'b1}) ? SEND : ACCUM;
        end
      end
      ACCUM: begin
        if (get_hsked) begin
          acc_d   = (add_ovf && sat_q) ? sat_val : sum_full[ACC_SIZE-1:0];
          ovf_d   = ovf_q | add_ovf;
          count_d = count_inc;
          if (count_inc == len_q) begin
            state_d = SEND;
          end
        end
      end
      SEND: begin
        if (send_hsked) begin
          state_d = IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out_ready = rst_n & ((state_q == IDLE) | (state_q == ACCUM));
  assign out_valid = (state_q == SEND);
  assign out_acc   = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid & ovf_q;

endmodule

// File: tb/tb_mul_product_accumulator.sv
// Directed bench for mul_product_accumulator: a 72-bit instance for the general
// cases plus a 65-bit instance to reach overflow and saturation quickly.
module tb_mul_product_accumulator;

  logic        clk;
  logic        rstN;
  logic [63:0] inProd;
  logic        inProdSigned;
  logic [7:0]  inLen;
  logic        inSatEn;
  logic        inValid;
  logic        inReady;

  logic        outReady72, outOvf72, outValid72;
  logic [71:0] outAcc72;
  logic        outReady65, outOvf65, outValid65;
  logic [64:0] outAcc65;

  int errCount   = 0;
  int checkCount = 0;

  mul_product_accumulator #(.PROD_SIZE(64), .ACC_SIZE(72), .LEN_W(8)) u_dut72 (
    .clk(clk), .rst_n(rstN), .in_prod(inProd), .in_prod_signed(inProdSigned),
    .in_len(inLen), .in_sat_en(inSatEn), .in_valid(inValid), .out_ready(outReady72),
    .out_acc(outAcc72), .out_ovf(outOvf72), .out_valid(outValid72), .in_ready(inReady)
  );

  mul_product_accumulator #(.PROD_SIZE(64), .ACC_SIZE(65), .LEN_W(8)) u_dut65 (
    .clk(clk), .rst_n(rstN), .in_prod(inProd), .in_prod_signed(inProdSigned),
    .in_len(inLen), .in_sat_en(inSatEn), .in_valid(inValid), .out_ready(outReady65),
    .out_acc(outAcc65), .out_ovf(outOvf65), .out_valid(outValid65), .in_ready(inReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if the stimulus sequence stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checkCount++;
    if (got !== exp) begin
      errCount++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sgn, input logic sat, input logic [7:0] len);
    inProdSigned = sgn;
    inSatEn      = sat;
    inLen        = len;
  endtask

  task automatic pushProd(input logic [63:0] p);
    inValid = 1'b1;
    inProd  = p;
    step();
  endtask

  task automatic releaseResult();
    inValid = 1'b0;
    inReady = 1'b1;
    step();
    inReady = 1'b0;
  endtask

  initial begin
    rstN    = 1'b0;
    inProd  = '0;
    inValid = 1'b0;
    inReady = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'd0);
    step();
    step();
    checkOutput("rst_ready", {71'd0, outReady72}, 72'd0);
    checkOutput("rst_valid", {71'd0, outValid72}, 72'd0);
    checkOutput("rst_acc", outAcc72, 72'd0);
    checkOutput("rst_ovf", {71'd0, outOvf72}, 72'd0);
    rstN = 1'b1;
    #1;
    checkOutput("idle_ready", {71'd0, outReady72}, 72'd1);

    // Unsigned group of three back-to-back products
    applyStimulus(1'b0, 1'b0, 8'd3);
    pushProd(64'd5);
    checkOutput("t1_valid_b1", {71'd0, outValid72}, 72'd0);
    pushProd(64'd7);
    checkOutput("t1_valid_b2", {71'd0, outValid72}, 72'd0);
    pushProd(64'd11);
    inValid = 1'b0;
    checkOutput("t1_valid", {71'd0, outValid72}, 72'd1);
    checkOutput("t1_acc", outAcc72, 72'd23);
    checkOutput("t1_ovf", {71'd0, outOvf72}, 72'd0);
    checkOutput("t1_ready_send", {71'd0, outReady72}, 72'd0);
    releaseResult();
    checkOutput("t1_ready_after", {71'd0, outReady72}, 72'd1);
    checkOutput("t1_valid_after", {71'd0, outValid72}, 72'd0);
    checkOutput("t1_acc_masked", outAcc72, 72'd0);

    // Signed: -6 + 4
    applyStimulus(1'b1, 1'b0, 8'd2);
    pushProd(64'hFFFF_FFFF_FFFF_FFFA);
    pushProd(64'd4);
    inValid = 1'b0;
    checkOutput("t2_valid", {71'd0, outValid72}, 72'd1);
    checkOutput("t2_acc", outAcc72, 72'hFF_FFFF_FFFF_FFFF_FFFE);
    checkOutput("t2_ovf", {71'd0, outOvf72}, 72'd0);
    releaseResult();

    // Unsigned overflow on the narrow accumulator, saturating
    applyStimulus(1'b0, 1'b1, 8'd3);
    for (int i = 0; i < 3; i++) pushProd(64'hFFFF_FFFF_FFFF_FFFF);
    inValid = 1'b0;
    checkOutput("t3_sat_acc", {7'd0, outAcc65}, {7'd0, 65'h1_FFFF_FFFF_FFFF_FFFF});
    checkOutput("t3_sat_ovf", {71'd0, outOvf65}, 72'd1);
    checkOutput("t3_wide_acc", outAcc72, 72'h02_FFFF_FFFF_FFFF_FFFD);
    checkOutput("t3_wide_ovf", {71'd0, outOvf72}, 72'd0);
    releaseResult();

    // Same products in wrap mode
    applyStimulus(1'b0, 1'b0, 8'd3);
    for (int i = 0; i < 3; i++) pushProd(64'hFFFF_FFFF_FFFF_FFFF);
    inValid = 1'b0;
    checkOutput("t3_wrap_acc", {7'd0, outAcc65}, {7'd0, 65'h0_FFFF_FFFF_FFFF_FFFD});
    checkOutput("t3_wrap_ovf", {71'd0, outOvf65}, 72'd1);
    releaseResult();

    // Signed saturation, positive then negative direction
    applyStimulus(1'b1, 1'b1, 8'd3);
    for (int i = 0; i < 3; i++) pushProd(64'h7FFF_FFFF_FFFF_FFFF);
    inValid = 1'b0;
    checkOutput("t3_spos_acc", {7'd0, outAcc65}, {7'd0, 65'h0_FFFF_FFFF_FFFF_FFFF});
    checkOutput("t3_spos_ovf", {71'd0, outOvf65}, 72'd1);
    checkOutput("t3_spos_wide", outAcc72, 72'h01_7FFF_FFFF_FFFF_FFFD);
    releaseResult();
    applyStimulus(1'b1, 1'b1, 8'd3);
    for (int i = 0; i < 3; i++) pushProd(64'h8000_0000_0000_0000);
    inValid = 1'b0;
    checkOutput("t3_sneg_acc", {7'd0, outAcc65}, {7'd0, 65'h1_0000_0000_0000_0000});
    checkOutput("t3_sneg_ovf", {71'd0, outOvf65}, 72'd1);
    releaseResult();

    // Bubbles between beats, then backpressure in SEND
    applyStimulus(1'b0, 1'b0, 8'd4);
    for (int i = 1; i <= 4; i++) begin
      pushProd(64'(i));
      if (i < 4) begin
        inValid = 1'b0;
        inProd  = 64'd1000;
        step();
      end
    end
    for (int i = 0; i < 5; i++) begin
      inValid = i[0];
      inProd  = 64'd50;
      checkOutput("t4_hold_acc", outAcc72, 72'd10);
      checkOutput("t4_hold_valid", {71'd0, outValid72}, 72'd1);
      checkOutput("t4_hold_ready", {71'd0, outReady72}, 72'd0);
      step();
    end
    releaseResult();
    checkOutput("t4_idle_ready", {71'd0, outReady72}, 72'd1);
    checkOutput("t4_idle_valid", {71'd0, outValid72}, 72'd0);

    // Zero length behaves as a single-product group
    applyStimulus(1'b0, 1'b0, 8'd0);
    pushProd(64'd9);
    inValid = 1'b0;
    checkOutput("t5_valid", {71'd0, outValid72}, 72'd1);
    checkOutput("t5_acc", outAcc72, 72'd9);
    releaseResult();

    // Reset in the middle of a group
    applyStimulus(1'b0, 1'b0, 8'd3);
    pushProd(64'd100);
    inValid = 1'b0;
    rstN    = 1'b0;
    #1;
    checkOutput("t6_ready_in_rst", {71'd0, outReady72}, 72'd0);
    step();
    rstN = 1'b1;
    #1;
    checkOutput("t6_ready", {71'd0, outReady72}, 72'd1);
    checkOutput("t6_valid", {71'd0, outValid72}, 72'd0);
    applyStimulus(1'b0, 1'b0, 8'd1);
    pushProd(64'd7);
    inValid = 1'b0;
    checkOutput("t6_new_valid", {71'd0, outValid72}, 72'd1);
    checkOutput("t6_new_acc", outAcc72, 72'd7);
    checkOutput("t6_new_ovf", {71'd0, outOvf72}, 72'd0);
    releaseResult();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
